hasti_cmd_master: RTL and testbench

HASTI_CMD_MASTER -- requirements
Module: hasti_cmd_master

---
 rtl/hasti_cmd_master_if.sv | 55 +++++
 rtl/hasti_cmd_master.sv | 144 ++++++++++++++
 tb/tb_hasti_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hasti_cmd_master_if.sv
// Bus bundle for hasti_cmd_master: command/response handshake plus the HASTI master port.
// The master modport is the block's view; the slave modport is the view of whoever drives it.
interface hasti_cmd_master_if;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned PROT_W  = 4;
  localparam int unsigned TRANS_W = 2;

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [SIZE_W-1:0] cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // HASTI master port
  logic [ADDR_W-1:0]  haddr;
  logic               hwrite;
  logic [SIZE_W-1:0]  hsize;
  logic [BURST_W-1:0] hburst;
  logic               hmastlock;
  logic [PROT_W-1:0]  hprot;
  logic [TRANS_W-1:0] htrans;
  logic [DATA_W-1:0]  hwdata;
  logic [DATA_W-1:0]  hrdata;
  logic               hready;
  logic               hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/hasti_cmd_master.sv
// Single-outstanding HASTI master: turns one command into one NONSEQ SINGLE transfer and a response.
// Define HASTI_CMD_MASTER_ALIGN_CHECK_EN to reject bad sizes / misaligned addresses without bus traffic.
module hasti_cmd_master (
  input  logic                hclk,
  input  logic                reset,
  hasti_cmd_master_if.master  bus
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned PROT_W  = 4;
  localparam int unsigned TRANS_W = 2;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = TRANS_W'(2'b00);
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = TRANS_W'(2'b10);
  localparam logic [BURST_W-1:0] HBURST_SINGLE = BURST_W'(3'b000);
  localparam logic [PROT_W-1:0]  HPROT_DATA    = PROT_W'(4'b0011);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [TRANS_W-1:0]  htrans_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic                hwrite_q;
  logic [SIZE_W-1:0]   hsize_q;
  logic [DATA_W-1:0]   hwdata_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cmd_fire_c;
  logic                misaligned_c;

  assign cmd_fire_c = bus.cmd_valid && cmd_ready_q;

`ifdef HASTI_CMD_MASTER_ALIGN_CHECK_EN
  // Sizes above word, odd halfwords and non-word-aligned words never reach the bus.
  always_comb begin
    misaligned_c = 1'b0;
    if (bus.cmd_size > SIZE_W'(3'd2))
      misaligned_c = 1'b1;
    else if (bus.cmd_size == SIZE_W'(3'd1) && bus.cmd_addr[0])
      misaligned_c = 1'b1;
    else if (bus.cmd_size == SIZE_W'(3'd2) && (bus.cmd_addr[1:0] != 2'b00))
      misaligned_c = 1'b1;
  end
`else
  assign misaligned_c = 1'b0;
`endif

  // Transfer sequencer; every bus-facing output comes straight from a flop.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire_c) begin
            cmd_ready_q <= 1'b0;
            if (misaligned_c) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state    <= ADDR;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= bus.cmd_addr;
              hwrite_q <= bus.cmd_write;
              hsize_q  <= bus.cmd_size;
              wdata_q  <= bus.cmd_wdata;
            end
          end
        end

        // Address phase holds until the slave accepts it.
        ADDR: begin
          if (bus.hready) begin
            state    <= DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= wdata_q;
          end
        end

        // Only the hready=1 cycle carries the final data/response; error's first cycle is a wait.
        DATA: begin
          if (bus.hready) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hwrite_q ? '0 : bus.hrdata;
            rsp_err_q   <= bus.hresp;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          htrans_q    <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hmastlock = 1'b0;
  assign bus.hprot     = HPROT_DATA;

endmodule

// File: tb/tb_hasti_cmd_master.sv
// Directed bench for hasti_cmd_master: cycle checks in the stimulus thread, responses via a scoreboard queue.
module tb_hasti_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic hclk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   nonseq_cnt;
  rsp_t exp_q[$];

  hasti_cmd_master_if bus ();

  hasti_cmd_master u_dut (
    .hclk  (hclk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    exp_q.push_back(r);
  endtask

  task automatic drive_cmd(input logic wr, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_size  = size;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  // Response monitor: a handshake completes on the next rising edge.
  always @(negedge hclk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      rsp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got rdata 0x%08h err %0b with no expected response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
          n_fail++;
          $display("FAIL sb_rsp: got rdata 0x%08h err %0b expected rdata 0x%08h err %0b",
                   bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  always @(negedge hclk) begin
    if (!reset && bus.htrans == 2'b10) nonseq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_checks = 0;
    n_fail = 0;
    nonseq_cnt = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 3'd0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;

    // reset values
    #12;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_htrans",    32'(bus.htrans), 32'd0);
    check("rst_haddr",     bus.haddr, 32'd0);
    check("rst_hwrite",    32'(bus.hwrite), 32'd0);
    check("rst_hsize",     32'(bus.hsize), 32'd0);
    check("rst_hwdata",    bus.hwdata, 32'd0);
    check("hburst",        32'(bus.hburst), 32'd0);
    check("hmastlock",     32'(bus.hmastlock), 32'd0);
    check("hprot",         32'(bus.hprot), 32'd3);
    tick();
    reset = 1'b0;
    tick();

    // word write, zero-wait slave
    drive_cmd(1'b1, 3'd2, 32'h0001_0000, 32'hDEAD_BEEF);
    push_exp(32'h0, 1'b0);
    check("wr_cmd_ready_n", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("wr_htrans_n1", 32'(bus.htrans), 32'd2);
    check("wr_haddr_n1",  bus.haddr, 32'h0001_0000);
    check("wr_hsize_n1",  32'(bus.hsize), 32'd2);
    check("wr_hwrite_n1", 32'(bus.hwrite), 32'd1);
    check("wr_cmd_ready_n1", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.hrdata = 32'hFFFF_FFFF;
    check("wr_htrans_n2", 32'(bus.htrans), 32'd0);
    check("wr_hwdata_n2", bus.hwdata, 32'hDEAD_BEEF);
    check("wr_rsp_valid_n2", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.hrdata = '0;
    check("wr_rsp_valid_n3", 32'(bus.rsp_valid), 32'd1);
    check("wr_rsp_rdata_n3", bus.rsp_rdata, 32'd0);
    check("wr_rsp_err_n3", 32'(bus.rsp_err), 32'd0);
    tick();
    check("wr_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // word read with three data-phase wait states
    drive_cmd(1'b0, 3'd2, 32'h0000_0004, 32'h0);
    push_exp(32'h1234_5678, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    check("rd_htrans_n1", 32'(bus.htrans), 32'd2);
    check("rd_hwrite_n1", 32'(bus.hwrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.hready = 1'b0;
      check("rd_wait_htrans", 32'(bus.htrans), 32'd0);
    end
    tick();
    bus.hready = 1'b1;
    bus.hrdata = 32'h1234_5678;
    check("rd_rsp_valid_n5", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.hrdata = '0;
    check("rd_rsp_valid_n6", 32'(bus.rsp_valid), 32'd1);
    check("rd_rsp_rdata_n6", bus.rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err_n6", 32'(bus.rsp_err), 32'd0);
    tick();

    // read with address-phase stall then two-cycle error response
    c0 = nonseq_cnt;
    drive_cmd(1'b0, 3'd2, 32'h0000_0008, 32'h0);
    push_exp(32'h0, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.hready = 1'b0;
    check("err_htrans_n1", 32'(bus.htrans), 32'd2);
    tick();
    bus.hready = 1'b1;
    check("err_htrans_stall", 32'(bus.htrans), 32'd2);
    check("err_haddr_stall", bus.haddr, 32'h0000_0008);
    tick();
    bus.hresp = 1'b1;
    bus.hready = 1'b0;
    check("err_htrans_d1", 32'(bus.htrans), 32'd0);
    tick();
    bus.hready = 1'b1;
    check("err_htrans_d2", 32'(bus.htrans), 32'd0);
    check("err_rsp_valid_d2", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.hresp = 1'b0;
    check("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("err_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("err_htrans_resp", 32'(bus.htrans), 32'd0);
    check("err_nonseq_cycles", 32'(nonseq_cnt - c0), 32'd2);
    tick();

    // response back-pressure with a competing command held on the port
    drive_cmd(1'b1, 3'd2, 32'h0000_0020, 32'h55AA_1234);
    push_exp(32'h0, 1'b0);
    bus.rsp_ready = 1'b0;
    tick();
    drive_cmd(1'b0, 3'd2, 32'h0000_0030, 32'h0);
    tick();
    tick();
    c0 = nonseq_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_htrans", 32'(bus.htrans), 32'd0);
      tick();
    end
    check("bp_no_nonseq", 32'(nonseq_cnt - c0), 32'd0);
    bus.rsp_ready = 1'b1;
    push_exp(32'hCAFE_F00D, 1'b0);
    check("bp_rsp_valid_hs", 32'(bus.rsp_valid), 32'd1);
    tick();
    check("bp_cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_new_htrans", 32'(bus.htrans), 32'd2);
    check("bp_new_haddr", bus.haddr, 32'h0000_0030);
    tick();
    bus.hrdata = 32'hCAFE_F00D;
    tick();
    bus.hrdata = '0;
    check("bp_new_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();

    // asynchronous reset in the data phase
    drive_cmd(1'b0, 3'd2, 32'h0000_0040, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.hready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_htrans", 32'(bus.htrans), 32'd0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_haddr", bus.haddr, 32'd0);
    tick();
    reset = 1'b0;
    bus.hready = 1'b1;
    tick();
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drive_cmd(1'b1, 3'd1, 32'h0000_0052, 32'h0BAD_0000);
    push_exp(32'h0, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    check("post_rst_haddr", bus.haddr, 32'h0000_0052);
    check("post_rst_hsize", 32'(bus.hsize), 32'd1);
    tick();
    check("post_rst_hwdata", bus.hwdata, 32'h0BAD_0000);
    tick();
    check("post_rst_rsp_valid_n3", 32'(bus.rsp_valid), 32'd1);
    tick();

    // misaligned word read
    c0 = nonseq_cnt;
    drive_cmd(1'b0, 3'd2, 32'h0000_0002, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
`ifdef HASTI_CMD_MASTER_ALIGN_CHECK_EN
    push_exp(32'h0, 1'b1);
    check("mis_rsp_valid_n1", 32'(bus.rsp_valid), 32'd1);
    check("mis_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("mis_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("mis_htrans", 32'(bus.htrans), 32'd0);
    tick();
    check("mis_no_nonseq", 32'(nonseq_cnt - c0), 32'd0);
`else
    push_exp(32'h0000_BEEF, 1'b0);
    check("mis_htrans", 32'(bus.htrans), 32'd2);
    check("mis_haddr", bus.haddr, 32'h0000_0002);
    tick();
    bus.hrdata = 32'h0000_BEEF;
    tick();
    bus.hrdata = '0;
    check("mis_rsp_valid_n3", 32'(bus.rsp_valid), 32'd1);
    tick();
    check("mis_one_nonseq", 32'(nonseq_cnt - c0), 32'd1);
`endif

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
